// File: rtl/filt_oup_requant.sv
// Output stage for filt_mac: decimate, round, shift, saturate, then buffer in a FIFO
// that feeds a valid/ready consumer.
module filt_oup_requant #(
   parameter int gp_inp_width  = 37,
   parameter int gp_oup_width  = 16,
   parameter int gp_shift      = 12,
   parameter int gp_dec        = 2,
   parameter int gp_fifo_depth = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst_an,
   input  logic                           i_ena,
   input  logic signed [gp_inp_width-1:0] i_data,
   input  logic                           i_done,
   input  logic                           i_ready,
   output logic signed [gp_oup_width-1:0] o_data,
   output logic                           o_valid,
   output logic                           o_sat,
   output logic                           o_ovf
);

   localparam int dw = (gp_dec > 1) ? $clog2(gp_dec) : 1;
   localparam int pw = $clog2(gp_fifo_depth);
   localparam int cw = $clog2(gp_fifo_depth + 1);
   localparam int ew = gp_inp_width + 1;

   localparam logic signed [ew-1:0] half    = ew'(1) <<< (gp_shift - 1);
   localparam logic signed [ew-1:0] sat_max = (ew'(1) <<< (gp_oup_width - 1)) - ew'(1);
   localparam logic signed [ew-1:0] sat_min = ~sat_max;
   localparam logic [dw-1:0]        dcnt_last = dw'(gp_dec - 1);
   localparam logic [cw-1:0]        count_full = cw'(gp_fifo_depth);

   logic [dw-1:0]                  dcnt;
   logic                           accept;
   logic                           keep;
   logic signed [ew-1:0]           sum;
   logic signed [ew-1:0]           r1_next;
   logic signed [ew-1:0]           r1;
   logic                           v1;
   logic                           clamp_hi;
   logic                           clamp_lo;
   logic signed [gp_oup_width-1:0] r2_next;
   logic signed [gp_oup_width-1:0] r2;
   logic                           v2;

   logic signed [gp_oup_width-1:0] mem [0:gp_fifo_depth-1];
   logic [pw-1:0]                  wr_ptr;
   logic [pw-1:0]                  rd_ptr;
   logic [pw-1:0]                  rd_next;
   logic [cw-1:0]                  count;
   logic [cw-1:0]                  count_next;
   logic                           empty;
   logic                           full;
   logic                           push;
   logic                           pop;
   logic signed [gp_oup_width-1:0] head_next;

   always_comb begin
      accept   = i_ena & i_done;
      keep     = accept && (dcnt == '0);
      // sign-extend by one bit so the rounding add cannot wrap
      sum      = {i_data[gp_inp_width-1], i_data} + half;
      r1_next  = sum >>> gp_shift;

      clamp_hi = (r1 > sat_max);
      clamp_lo = (r1 < sat_min);
      if (clamp_hi)
         r2_next = sat_max[gp_oup_width-1:0];
      else if (clamp_lo)
         r2_next = sat_min[gp_oup_width-1:0];
      else
         r2_next = r1[gp_oup_width-1:0];

      empty      = (count == '0);
      full       = (count == count_full);
      pop        = !empty && i_ready;
      push       = v2 && (!full || pop);
      rd_next    = pop ? rd_ptr + pw'(1) : rd_ptr;
      count_next = count + cw'(push) - cw'(pop);
      // the incoming sample becomes the head only when the FIFO drains to it this cycle
      head_next  = (push && (wr_ptr == rd_next)) ? r2 : mem[rd_next];

      o_valid    = !empty;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_an) begin
         dcnt   <= '0;
         r1     <= '0;
         v1     <= 1'b0;
         r2     <= '0;
         v2     <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         o_data <= '0;
         o_sat  <= 1'b0;
         o_ovf  <= 1'b0;
      end else begin
         if (accept)
            dcnt <= (dcnt == dcnt_last) ? '0 : dcnt + dw'(1);

         v1 <= keep;
         if (keep)
            r1 <= r1_next;

         v2 <= v1;
         if (v1) begin
            r2 <= r2_next;
            if (clamp_hi || clamp_lo)
               o_sat <= 1'b1;
         end

         if (push)
            wr_ptr <= wr_ptr + pw'(1);
         if (v2 && full && !pop)
            o_ovf <= 1'b1;

         rd_ptr <= rd_next;
         count  <= count_next;
         if (count_next != '0)
            o_data <= head_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_an && push)
         mem[wr_ptr] <= r2;
   end

endmodule

// File: tb/tb_filt_oup_requant.sv
// Directed bench for filt_oup_requant: one instance with gp_dec=1, one with gp_dec=2.
module tb_filt_oup_requant;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                ena;
   logic                ready;
   logic                done1;
   logic                done2;
   logic signed [36:0]  data;
   logic signed [15:0]  odata1;
   logic signed [15:0]  odata2;
   logic                valid1, valid2;
   logic                sat1, sat2;
   logic                ovf1, ovf2;

   int total = 0;
   int bad   = 0;

   filt_oup_requant #(.gp_dec(1)) u_dut1 (
      .i_clk    (clk),
      .i_rst_an (rst_n),
      .i_ena    (ena),
      .i_data   (data),
      .i_done   (done1),
      .i_ready  (ready),
      .o_data   (odata1),
      .o_valid  (valid1),
      .o_sat    (sat1),
      .o_ovf    (ovf1)
   );

   filt_oup_requant #(.gp_dec(2)) u_dut2 (
      .i_clk    (clk),
      .i_rst_an (rst_n),
      .i_ena    (ena),
      .i_data   (data),
      .i_done   (done2),
      .i_ready  (ready),
      .o_data   (odata2),
      .o_valid  (valid2),
      .o_sat    (sat2),
      .o_ovf    (ovf2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send1(input logic signed [36:0] v);
      done1 = 1'b1;
      data  = v;
      tick();
      done1 = 1'b0;
   endtask

   int t1_in  [4] = '{411648, -2048, -2049, 6143};
   int t1_exp [4] = '{101, 0, -1, 1};

   initial begin
      rst_n = 1'b0;
      ena   = 1'b1;
      ready = 1'b1;
      done1 = 1'b0;
      done2 = 1'b0;
      data  = '0;
      tick();
      tick();
      chk("rst_valid", valid1, 0);
      chk("rst_data",  odata1, 0);
      chk("rst_sat",   sat1,   0);
      chk("rst_ovf",   ovf1,   0);
      chk("rst_valid2", valid2, 0);
      rst_n = 1'b1;

      // rounding
      for (int i = 0; i < 6; i++) begin
         done1 = (i < 4);
         data  = (i < 4) ? 37'(t1_in[i]) : '0;
         tick();
         if (i == 1)
            chk("t1_latency", valid1, 0);
         if (i >= 2) begin
            chk($sformatf("t1_data%0d", i - 2), odata1, t1_exp[i-2]);
            chk($sformatf("t1_valid%0d", i - 2), valid1, 1);
         end
      end
      tick();
      chk("t1_empty", valid1, 0);
      chk("t1_hold",  odata1, 1);
      chk("t1_sat",   sat1,   0);

      // saturation
      send1(37'sd1073741824);
      chk("t2_sat_pre", sat1, 0);
      tick();
      chk("t2_sat_set", sat1, 1);
      tick();
      chk("t2_pos", odata1, 32767);
      send1(-37'sd1073741824);
      tick();
      tick();
      chk("t2_neg", odata1, -32768);
      chk("t2_sat_neg", sat1, 1);
      send1(37'sd4096);
      tick();
      tick();
      chk("t2_one", odata1, 1);
      chk("t2_sat_keep", sat1, 1);
      tick();
      chk("t2_empty", valid1, 0);

      // overflow with consumer stalled
      ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         done1 = (i < 6);
         data  = 37'((i + 1) * 4096);
         tick();
         if (i == 2) begin
            chk("t4_valid", valid1, 1);
            chk("t4_head",  odata1, 1);
         end
         if (i == 5) chk("t4_ovf_pre", ovf1, 0);
         if (i == 6) chk("t4_ovf_set", ovf1, 1);
         if (i == 7) begin
            chk("t4_hold",  odata1, 1);
            chk("t4_valid_hold", valid1, 1);
         end
      end
      ready = 1'b1;
      for (int p = 0; p < 4; p++) begin
         tick();
         if (p < 3)
            chk($sformatf("t4_pop%0d", p), odata1, p + 2);
         else
            chk("t4_drained", valid1, 0);
      end
      chk("t4_last", odata1, 4);

      // decimation and enable (gp_dec=2 instance)
      done1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         done2 = (i < 6);
         data  = 37'((i + 1) * 4096);
         tick();
         if (i == 2) begin
            chk("t3_first", odata2, 1);
            chk("t3_first_v", valid2, 1);
         end
         if (i == 3) chk("t3_gap", valid2, 0);
         if (i == 4) chk("t3_second", odata2, 3);
         if (i == 6) chk("t3_third", odata2, 5);
         if (i == 7) chk("t3_gap2", valid2, 0);
      end
      ena   = 1'b0;
      done2 = 1'b1;
      data  = 37'(100 * 4096);
      tick();
      tick();
      done2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t3_ena_off%0d", i), valid2, 0);
      end
      ena   = 1'b1;
      done2 = 1'b1;
      data  = 37'(7 * 4096);
      tick();
      done2 = 1'b0;
      tick();
      chk("t3_lat", valid2, 0);
      tick();
      chk("t3_seven", odata2, 7);
      chk("t3_seven_v", valid2, 1);
      tick();

      // reset mid-operation
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         done1 = (i < 3);
         data  = 37'((10 + i) * 4096);
         tick();
      end
      chk("t6_pre_head", odata1, 10);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t6_valid", valid1, 0);
      chk("t6_data",  odata1, 0);
      chk("t6_sat",   sat1,   0);
      chk("t6_ovf",   ovf1,   0);
      chk("t6_data2", odata2, 0);
      chk("t6_sat2",  sat2,   0);
      chk("t6_ovf2",  ovf2,   0);
      ready = 1'b1;
      tick();
      chk("t6_flushed", valid1, 0);
      done1 = 1'b1;
      done2 = 1'b1;
      data  = 37'(13 * 4096);
      tick();
      done1 = 1'b0;
      done2 = 1'b0;
      tick();
      chk("t6_lat", valid1, 0);
      tick();
      chk("t6_next",    odata1, 13);
      chk("t6_next_v",  valid1, 1);
      chk("t6_next2",   odata2, 13);
      chk("t6_next2_v", valid2, 1);
      tick();

      // full FIFO with a simultaneous pop
      chk("t5_empty", valid1, 0);
      for (int i = 0; i < 11; i++) begin
         done1 = (i < 5);
         data  = 37'((i + 1) * 4096);
         ready = (i >= 6);
         tick();
         if (i == 5) begin
            chk("t5_head", odata1, 1);
            chk("t5_ovf_pre", ovf1, 0);
         end
         if (i == 6) begin
            chk("t5_ovf", ovf1, 0);
            chk("t5_pop1", odata1, 2);
         end
         if (i >= 7 && i <= 9)
            chk($sformatf("t5_pop%0d", i - 5), odata1, i - 4);
         if (i == 10)
            chk("t5_drained", valid1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
